// File: rtl/serial_adder.sv
// serial_adder -- bit-serial WIDTH-bit adder.
//
// One 1-bit full-adder stage plus a registered carry is stepped over the
// operands LSB first, one bit per clock. A word takes WIDTH RUN cycles
// followed by a single DONE cycle, so throughput is one result per WIDTH+1
// cycles. Trades latency for a very small datapath.
//
// Ports:
//   clk        single system clock, rising-edge active
//   rst        synchronous, active-high reset
//   start      request; sampled only when not busy (IDLE or DONE)
//   a, b       WIDTH-bit operands, captured on an accepted start
//   cin        carry-in, captured on an accepted start
//   busy       high while bits are being processed (RUN)
//   done       one-cycle pulse; sum/cout just updated
//   sum        registered WIDTH-bit result, holds until the next completion
//   cout       registered carry-out, holds until the next completion
//   state_dbg  current FSM state (0=IDLE, 1=RUN, 2=DONE) for observation
//
// Handshake: a request is accepted at a rising edge where start=1 and
// busy=0. Once accepted, a/b/cin are ignored until the operation finishes;
// start is ignored while busy=1. done marks the single cycle in which the
// new sum/cout first appear; there is no backpressure on the result.

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       state_dbg
);

  // Counter must hold WIDTH-1 without wrapping; keep at least one bit so
  // the WIDTH=1 build still has a legal vector.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // partial sum, filled from the MSB end
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // The 1-bit full-adder cell driven every cycle.
  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] s_msb;

  always_comb begin
    fa_s = a_q[0] ^ b_q[0] ^ carry_q;
    fa_c = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    // New sum bit placed at the MSB so that after WIDTH right shifts the
    // first (LSB) result bit has landed at bit 0.
    s_msb            = '0;
    s_msb[WIDTH-1]   = fa_s;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        acc_d   = (acc_q >> 1) | s_msb;
        carry_d = fa_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          // Final bit: publish the completed word and carry together.
          sum_d   = (acc_q >> 1) | s_msb;
          cout_d  = fa_c;
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: a WIDTH=8 instance exercised with
// directed and random operands, plus a WIDTH=1 instance swept over the
// full-adder truth table.

module tb_serial_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- WIDTH=8 instance ----------------
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic       busy, done, cout;
  logic [7:0] sum;
  logic [1:0] state_dbg;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .state_dbg(state_dbg)
  );

  // ---------------- WIDTH=1 instance ----------------
  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       cin1 = 1'b0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;
  logic [1:0] state_dbg1;

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .state_dbg(state_dbg1)
  );

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  logic [8:0] last_res = '0;   // last completed {cout,sum} the outputs must hold
  int n_vec = 0;
  int n_err = 0;
  logic prev_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Result monitor: every done pulse pops one expected {cout,sum}.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) check("unexpected_done", 1, 0);
      else check("result", {cout, sum}, exp_q.pop_front());
      check("done_single_cycle", prev_done, 0);
    end
    prev_done <= done;
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end at a negedge.
  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_hold", {cout, sum}, last_res);
    end
  endtask

  // One operation; poke=1 pulses start with other operands during RUN.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic cv, input bit poke);
    logic [8:0] e;
    int nb;
    bit got;
    e = {1'b0, av} + {1'b0, bv} + {8'd0, cv};
    a = av; b = bv; cin = cv; start = 1'b1;
    exp_q.push_back(e);
    nb = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) got = 1;
      else begin
        if (busy) begin
          nb++;
          check("hold_during_run", {cout, sum}, last_res);
        end
        if (poke && nb == 3) begin
          start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b1;
        end
      end
    end
    if (!got) check("done_timeout", 0, 1);
    check("busy_cycles", nb, 8);
    last_res = e;
  endtask

  task automatic back_to_back(input int nops);
    logic [8:0] e;
    int gap, k;
    a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255)); cin = 1'($urandom_range(0, 1));
    e = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    exp_q.push_back(e);
    start = 1'b1;
    gap = 0; k = 0;
    for (int i = 0; i < 20 * nops && k < nops; i++) begin
      @(negedge clk);
      gap++;
      if (done) begin
        check("b2b_gap", gap, 9);
        gap = 0; k++;
        last_res = e;
        if (k < nops) begin
          a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255)); cin = 1'($urandom_range(0, 1));
          e = {1'b0, a} + {1'b0, b} + {8'd0, cin};
          exp_q.push_back(e);
        end else start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_count", k, nops);
  endtask

  task automatic reset_mid_op();
    int nb;
    a = 8'h5F; b = 8'h73; cin = 1'b1; start = 1'b1;
    exp_q.push_back({1'b0, a} + {1'b0, b} + 9'd1);
    nb = 0;
    for (int i = 0; i < 20 && nb < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) nb++;
    end
    check("rst_reached_run4", nb, 4);
    rst = 1'b1;
    exp_q.delete();   // partial result is discarded
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", {cout, sum}, 0);
    check("rst_state", state_dbg, 0);
    last_res = '0;
    idle_check(12);
  endtask

  task automatic width1_sweep();
    logic [1:0] tbl [8];
    logic [2:0] v;
    int nb;
    bit got;
    tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
      nb = 0; got = 0;
      for (int j = 0; j < 10 && !got; j++) begin
        @(negedge clk);
        start1 = 1'b0;
        if (done1) got = 1;
        else if (busy1) nb++;
      end
      if (!got) check("w1_timeout", 0, 1);
      check("w1_busy_cycles", nb, 1);
      check("w1_result", {cout1, sum1}, tbl[i]);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", {cout, sum}, 0);
    check("reset_state", state_dbg, 0);
    rst = 1'b0;
    idle_check(10);

    run_op(8'h3C, 8'h42, 1'b0, 0);     // 0x07E
    idle_check(3);
    run_op(8'hFF, 8'h01, 1'b0, 0);     // 0x100
    run_op(8'hA5, 8'h5A, 1'b1, 0);     // 0x100, first result held during run
    idle_check(2);
    run_op(8'h80, 8'h7F, 1'b0, 1);     // 0x0FF despite start poke mid-run
    idle_check(2);
    run_op(8'hFF, 8'hFF, 1'b1, 0);     // 0x1FF
    idle_check(2);

    back_to_back(6);
    idle_check(2);

    reset_mid_op();
    width1_sweep();
    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
